// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_t;

  localparam int unsigned WORD_BYTES = 4;

  // One queued instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH x fetch_entry_t FIFO with a registered head.
// Ports: clk, rst (sync, active-high), push/wdata, pop, flush (wins over push),
//        head_valid/head (registered head entry, holds last value when empty), level.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  fetch_entry_t  wdata,
  input  logic          pop,
  input  logic          flush,
  output logic          head_valid,
  output fetch_entry_t  head,
  output logic [LW-1:0] level
);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [LW-1:0]  level_n;
  logic           pop_ok, push_ok;
  fetch_entry_t   head_n;

  assign pop_ok  = pop && head_valid && !flush;
  assign push_ok = push && !flush;

  // Pointer/level update; the new head is looked up at the post-update read pointer.
  always_comb begin
    wr_ptr_n = wr_ptr;
    rd_ptr_n = rd_ptr;
    level_n  = level;
    if (flush) begin
      wr_ptr_n = '0;
      rd_ptr_n = '0;
      level_n  = '0;
    end else begin
      if (push_ok) wr_ptr_n = AW'(wr_ptr + AW'(1));
      if (pop_ok)  rd_ptr_n = AW'(rd_ptr + AW'(1));
      level_n = LW'(level + LW'(push_ok) - LW'(pop_ok));
    end
    // Write pointer meets the new read pointer only when the pushed entry becomes head.
    head_n = (push_ok && (wr_ptr == rd_ptr_n)) ? wdata : mem[rd_ptr_n];
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      head_valid <= 1'b0;
      head       <= '0;
    end else begin
      wr_ptr     <= wr_ptr_n;
      rd_ptr     <= rd_ptr_n;
      level      <= level_n;
      head_valid <= (level_n != '0);
      if (level_n != '0) head <= head_n;
    end
  end

endmodule

// File: rtl/instr_fetch_buffer.sv
// Fetch stage: reads byte-wide imem, assembles big-endian words, queues {inst, pc}.
// Ports: clk, rst (sync, active-high); imem_req/imem_addr/imem_ack/imem_rdata byte memory;
//        inst_valid/inst_data/inst_pc/inst_ready consumer handshake; redir_valid/redir_pc
//        redirect+flush; fifo_level occupancy.
// Optional macro FETCH_PERF_CNT_EN adds perf_stall_cyc (full-FIFO idle cycles, saturating)
// and perf_flush_cnt (redirect cycles, wrapping).
module instr_fetch_buffer
  import fetch_pkg::*;
#(
  parameter  int unsigned DEPTH      = 4,
  parameter  logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter  int unsigned IMEM_ABITS = 5,
  localparam int unsigned LW         = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_req,
  output logic [31:0]   imem_addr,
  input  logic          imem_ack,
  input  logic [7:0]    imem_rdata,
  output logic          inst_valid,
  output logic [31:0]   inst_data,
  output logic [31:0]   inst_pc,
  input  logic          inst_ready,
  input  logic          redir_valid,
  input  logic [31:0]   redir_pc,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]   perf_stall_cyc,
  output logic [15:0]   perf_flush_cnt,
`endif
  output logic [LW-1:0] fifo_level
);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("DEPTH must be a power of two >= 2");
  end
  if ((IMEM_ABITS < 2) || (IMEM_ABITS > 32)) begin : g_bad_abits
    $error("IMEM_ABITS must be in 2..32");
  end

  fetch_state_t state, state_n;
  logic [31:0]  fetch_pc, fetch_pc_n, imem_addr_n;
  logic [1:0]   byte_idx, byte_idx_n;
  logic [23:0]  word_buf;
  logic         imem_req_n;
  logic         ack_ok, word_done, pop_fire;
  logic [LW-1:0] level_after;
  fetch_entry_t push_entry, head;

  // An ack counts only while requesting and not being redirected.
  assign ack_ok      = imem_req && imem_ack && !redir_valid;
  assign word_done   = ack_ok && (byte_idx == 2'(WORD_BYTES - 1));
  assign pop_fire    = inst_valid && inst_ready && !redir_valid;
  assign level_after = LW'(fifo_level + LW'(word_done) - LW'(pop_fire));
  assign push_entry  = '{pc: fetch_pc, inst: {word_buf, imem_rdata}};

  // Next-state: redirect first, then IDLE/FETCH sequencing.
  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    byte_idx_n = byte_idx;
    imem_req_n = imem_req;
    if (redir_valid) begin
      state_n    = FETCH;
      fetch_pc_n = {redir_pc[31:2], 2'b00};
      byte_idx_n = '0;
      imem_req_n = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (fifo_level < LW'(DEPTH)) begin
            state_n    = FETCH;
            imem_req_n = 1'b1;
          end
        end
        FETCH: begin
          imem_req_n = 1'b1;
          if (ack_ok) begin
            byte_idx_n = 2'(byte_idx + 2'd1);
            if (word_done) begin
              fetch_pc_n = fetch_pc + 32'(WORD_BYTES);
              if (level_after == LW'(DEPTH)) begin
                state_n    = IDLE;
                imem_req_n = 1'b0;
              end
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
    imem_addr_n = fetch_pc_n + 32'(byte_idx_n);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      byte_idx  <= '0;
      word_buf  <= '0;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      state     <= state_n;
      fetch_pc  <= fetch_pc_n;
      byte_idx  <= byte_idx_n;
      imem_req  <= imem_req_n;
      imem_addr <= imem_addr_n;
      // Bytes 0..2 shift in MSB-first; byte 3 is taken straight from imem_rdata.
      if (ack_ok) word_buf <= {word_buf[15:0], imem_rdata};
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cyc <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if ((state == IDLE) && (fifo_level == LW'(DEPTH)) && (perf_stall_cyc != '1))
        perf_stall_cyc <= perf_stall_cyc + 32'd1;
      if (redir_valid) perf_flush_cnt <= perf_flush_cnt + 16'd1;
    end
  end
`endif

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (word_done),
    .wdata      (push_entry),
    .pop        (inst_ready),
    .flush      (redir_valid),
    .head_valid (inst_valid),
    .head       (head),
    .level      (fifo_level)
  );

  assign inst_data = head.inst;
  assign inst_pc   = head.pc;

endmodule
